// File: rtl/add_share_arb.sv
// add_share_arb: round-robin scheduler sharing one pipelined adder between
// four requesters. Grants at most one requester per cycle, registers its
// operands onto the adder inputs and tracks the requester ID through a tag
// pipe so that each result comes back labelled with its owner.
// Optional build macro: ADD_SHARE_ARB_PRIO_EN (requester 0 gets strict
// priority, requesters 1..3 round-robin among themselves).
module add_share_arb #(
    parameter int LAT = 4,
    parameter int W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [3:0]     req_valid,
    input  logic [4*W-1:0] req_a,
    input  logic [4*W-1:0] req_b,
    input  logic [3:0]     req_ci,
    output logic [3:0]     req_ready,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    output logic           add_ci,
    input  logic [W-1:0]   add_s,
    input  logic           add_co,
    output logic           rsp_valid,
    output logic [1:0]     rsp_id,
    output logic [W-1:0]   rsp_s,
    output logic           rsp_co,
    output logic           busy
);

    logic [W-1:0] op_a [4];
    logic [W-1:0] op_b [4];

    logic [1:0]   ptr_reg;
    logic [1:0]   ptr_next;
    logic         grant_any;
    logic [1:0]   win_id;
    logic [1:0]   cand;

    logic [W-1:0] add_a_reg;
    logic [W-1:0] add_b_reg;
    logic         add_ci_reg;

    // Tag pipe: stage 0 is loaded on the accept edge, stage LAT drives the
    // response, so a result appears in the cycle after edge accept+LAT.
    logic         tag_v_reg  [LAT+1];
    logic [1:0]   tag_id_reg [LAT+1];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign op_a[gi] = req_a[gi*W +: W];
            assign op_b[gi] = req_b[gi*W +: W];
        end
    endgenerate

`ifdef ADD_SHARE_ARB_PRIO_EN
    // Successor within the 1..3 ring used by the low-priority requesters.
    function automatic logic [1:0] next3(input logic [1:0] x);
        return (x == 2'd3) ? 2'd1 : x + 2'd1;
    endfunction
`endif

    // Winner search and pointer update; reset and en low suppress any grant.
    always_comb begin
        grant_any = 1'b0;
        win_id    = 2'd0;
        ptr_next  = ptr_reg;
        cand      = ptr_reg;
        if (en && !rst) begin
`ifdef ADD_SHARE_ARB_PRIO_EN
            if (req_valid[0]) begin
                grant_any = 1'b1;
                win_id    = 2'd0;
            end else begin
                // A pointer of 0 (reset value) starts the ring at 1.
                cand = (ptr_reg == 2'd0) ? 2'd1 : ptr_reg;
                for (int k = 0; k < 3; k++) begin
                    if (!grant_any && req_valid[cand]) begin
                        grant_any = 1'b1;
                        win_id    = cand;
                    end
                    cand = next3(cand);
                end
            end
            // Grants to requester 0 leave the low-priority ring untouched.
            if (grant_any && win_id != 2'd0)
                ptr_next = next3(win_id);
`else
            for (int k = 0; k < 4; k++) begin
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    win_id    = cand;
                end
                cand = cand + 2'd1;
            end
            if (grant_any)
                ptr_next = win_id + 2'd1;
`endif
        end
    end

    assign req_ready = grant_any ? (4'b0001 << win_id) : 4'b0000;

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst)
            ptr_reg <= 2'd0;
        else
            ptr_reg <= ptr_next;
    end

    // Adder operand registers; they hold their value on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a_reg  <= '0;
            add_b_reg  <= '0;
            add_ci_reg <= 1'b0;
        end else if (grant_any) begin
            add_a_reg  <= op_a[win_id];
            add_b_reg  <= op_b[win_id];
            add_ci_reg <= req_ci[win_id];
        end
    end

    // Tag pipe shifts every edge; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= LAT; k++) begin
                tag_v_reg[k]  <= 1'b0;
                tag_id_reg[k] <= 2'd0;
            end
        end else begin
            tag_v_reg[0]  <= grant_any;
            tag_id_reg[0] <= win_id;
            for (int k = 1; k <= LAT; k++) begin
                tag_v_reg[k]  <= tag_v_reg[k-1];
                tag_id_reg[k] <= tag_id_reg[k-1];
            end
        end
    end

    // busy covers every stage, including the one just issued.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= LAT; k++)
            busy = busy | tag_v_reg[k];
    end

    assign add_a     = add_a_reg;
    assign add_b     = add_b_reg;
    assign add_ci    = add_ci_reg;
    assign rsp_valid = tag_v_reg[LAT];
    assign rsp_id    = tag_id_reg[LAT];
    assign rsp_s     = add_s;
    assign rsp_co    = add_co;

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: models the external LAT-stage adder, keeps a
// scoreboard of expected results pushed on every handshake and popped on
// every response, and runs one task per scenario.
module tb_add_share_arb;

    localparam int LAT = 4;
    localparam int W   = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en  = 1'b1;
    logic [3:0]     req_valid = '0;
    logic [4*W-1:0] req_a = '0;
    logic [4*W-1:0] req_b = '0;
    logic [3:0]     req_ci = '0;
    logic [3:0]     req_ready;
    logic [W-1:0]   add_a, add_b, add_s, rsp_s;
    logic           add_ci, add_co, rsp_valid, rsp_co, busy;
    logic [1:0]     rsp_id;

    add_share_arb #(.LAT(LAT), .W(W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
        .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_s(add_s), .add_co(add_co),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_co(rsp_co),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External adder model: LAT register stages from operands to result.
    logic [W:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign {add_co, add_s} = apipe[LAT-1];

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] s;
        logic         co;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0, passed = 0;
    int cyc = 0, acc_count = 0, rsp_count = 0, last_rsp_cyc = 0;
    logic [1:0]   last_id;
    logic [W-1:0] last_s;
    logic         last_co;

    // Scoreboard monitor: sample between edges.
    always @(negedge clk) begin
        logic [3:0] hs;
        exp_t e, g;
        cyc = cyc + 1;
        if (rst) begin
            sb.delete();
        end else begin
            if (rsp_valid) begin
                rsp_count = rsp_count + 1;
                last_rsp_cyc = cyc;
                last_id = rsp_id; last_s = rsp_s; last_co = rsp_co;
                total = total + 1;
                if (sb.size() == 0) begin
                    $display("FAIL rsp_unexpected: got id=%0d s=%h, required no response", rsp_id, rsp_s);
                end else begin
                    passed = passed + 1;
                    g = sb.pop_front();
                    total = total + 1;
                    if (rsp_id !== g.id) $display("FAIL rsp_id: got %0d required %0d", rsp_id, g.id);
                    else passed = passed + 1;
                    total = total + 1;
                    if ({rsp_co, rsp_s} !== {g.co, g.s}) $display("FAIL rsp_sum: got %h_%h required %h_%h", rsp_co, rsp_s, g.co, g.s);
                    else passed = passed + 1;
                    total = total + 1;
                    if (cyc - g.cyc !== LAT + 1) $display("FAIL rsp_latency: got %0d required %0d", cyc - g.cyc, LAT + 1);
                    else passed = passed + 1;
                    $display("rsp id=%0d s=%h co=%0d cyc=%0d", rsp_id, rsp_s, rsp_co, cyc);
                end
            end
            hs = req_valid & req_ready;
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) begin
                    e.id  = 2'(i);
                    {e.co, e.s} = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]} + {{W{1'b0}}, req_ci[i]};
                    e.cyc = cyc;
                    sb.push_back(e);
                    acc_count = acc_count + 1;
                    $display("acc id=%0d a=%h b=%h ci=%0d cyc=%0d", i, req_a[i*W +: W], req_b[i*W +: W], req_ci[i], cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_ci[i] = ci;
    endtask

    // Raise valid on the mask; each requester drops valid after its handshake.
    task automatic run_mask(input logic [3:0] mask);
        logic [3:0] g;
        req_valid = mask;
        for (int n = 0; n < 20 && req_valid != 4'b0; n++) begin
            sample();
            g = req_valid & req_ready;
            tick();
            req_valid = req_valid & ~g;
        end
        total = total + 1;
        if (req_valid !== 4'b0) $display("FAIL grant_timeout: got pending=%b required 0000", req_valid);
        else passed = passed + 1;
        req_valid = '0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < 40) begin
            tick(); n++;
        end
        total = total + 1;
        if (busy !== 1'b0 || sb.size() != 0) $display("FAIL drain: got busy=%b pending=%0d required 0/0", busy, sb.size());
        else passed = passed + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF;
        tick(); tick();
        sample();
        total = total + 1;
        if ({add_a, add_b, add_ci, rsp_valid, rsp_id, busy, req_ready} !== '0)
            $display("FAIL reset_state: got a=%h b=%h ci=%b v=%b id=%0d busy=%b rdy=%b required all 0",
                     add_a, add_b, add_ci, rsp_valid, rsp_id, busy, req_ready);
        else passed = passed + 1;
        tick();
        req_valid = '0; rst = 1'b0;
    endtask

    task automatic test_single();
        int r0 = rsp_count;
        set_op(0, 32'h00002475, 32'h30561c86, 1'b0);
        run_mask(4'b0001);
        drain();
        total = total + 1;
        if (rsp_count - r0 !== 1 || last_id !== 2'd0 || last_s !== 32'h305640FB || last_co !== 1'b0)
            $display("FAIL single_op: got n=%0d id=%0d s=%h co=%b required 1/0/305640fb/0", rsp_count - r0, last_id, last_s, last_co);
        else passed = passed + 1;
    endtask

    task automatic test_carry();
        set_op(2, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_mask(4'b0100);
        drain();
        total = total + 1;
        if (last_id !== 2'd2 || last_s !== 32'h0 || last_co !== 1'b1)
            $display("FAIL carry_wrap: got id=%0d s=%h co=%b required 2/00000000/1", last_id, last_s, last_co);
        else passed = passed + 1;
        set_op(3, 32'ha0987557, 32'hff004ab4, 1'b1);
        run_mask(4'b1000);
        drain();
        total = total + 1;
        if (last_id !== 2'd3 || last_s !== 32'h9F98C00C || last_co !== 1'b1)
            $display("FAIL carry_ci: got id=%0d s=%h co=%b required 3/9f98c00c/1", last_id, last_s, last_co);
        else passed = passed + 1;
    endtask

    task automatic test_fairness();
        int a0 = acc_count, r0 = rsp_count;
        logic [3:0] want;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 32'(i), 32'h0, 1'b0);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            sample();
`ifdef ADD_SHARE_ARB_PRIO_EN
            want = 4'b0001;
`else
            want = 4'b0001 << (k % 4);
`endif
            total = total + 1;
            if (req_ready !== want) $display("FAIL fair_grant%0d: got %b required %b", k, req_ready, want);
            else passed = passed + 1;
            tick();
        end
        req_valid = '0;
        drain();
        total = total + 1;
        if (acc_count - a0 !== 8 || rsp_count - r0 !== 8)
            $display("FAIL fair_count: got acc=%0d rsp=%0d required 8/8", acc_count - a0, rsp_count - r0);
        else passed = passed + 1;
    endtask

    task automatic test_en_gating();
        int r0 = rsp_count, low_cyc = 0;
        logic any_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_op(i, $urandom, $urandom, 1'($urandom_range(1)));
        run_mask(4'b0111);
        en = 1'b0; req_valid = 4'b1000;
        for (int n = 0; n < 20 && low_cyc == 0; n++) begin
            sample();
            if (req_ready !== 4'b0) any_ready = 1'b1;
            if (busy === 1'b0) low_cyc = cyc;
        end
        req_valid = '0;
        total = total + 1;
        if (any_ready) $display("FAIL en_ready: got grant required 0000");
        else passed = passed + 1;
        total = total + 1;
        if (rsp_count - r0 !== 3) $display("FAIL en_pulses: got %0d required 3", rsp_count - r0);
        else passed = passed + 1;
        total = total + 1;
        if (low_cyc !== last_rsp_cyc + 1) $display("FAIL en_busy_fall: got cyc %0d required %0d", low_cyc, last_rsp_cyc + 1);
        else passed = passed + 1;
        tick();
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int r0;
        set_op(1, 32'h11111111, 32'h22222222, 1'b0);
        set_op(2, 32'h33333333, 32'h44444444, 1'b1);
        run_mask(4'b0110);
        rst = 1'b1;
        tick();
        r0 = rsp_count;
        sample();
        total = total + 1;
        if ({add_a, add_b, add_ci, rsp_valid, rsp_id, busy, req_ready} !== '0)
            $display("FAIL rst_mid_state: got a=%h b=%h ci=%b v=%b id=%0d busy=%b rdy=%b required all 0",
                     add_a, add_b, add_ci, rsp_valid, rsp_id, busy, req_ready);
        else passed = passed + 1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < LAT + 3; n++) tick();
        total = total + 1;
        if (rsp_count !== r0) $display("FAIL rst_mid_pulses: got %0d required 0", rsp_count - r0);
        else passed = passed + 1;
        for (int i = 0; i < 4; i++) set_op(i, 32'(i + 16), 32'h5, 1'b0);
        req_valid = 4'hF;
        sample();
        total = total + 1;
        if (req_ready !== 4'b0001) $display("FAIL rst_mid_ptr: got %b required 0001", req_ready);
        else passed = passed + 1;
        tick();
        req_valid = '0;
        drain();
    endtask

    task automatic test_back_to_back();
        int a0 = acc_count, r0 = rsp_count;
        set_op(1, 32'hdeadbeef, 32'h12345678, 1'b1);
        run_mask(4'b0010);
        for (int n = 0; n < LAT - 1; n++) tick();
        set_op(3, 32'h80000000, 32'h80000000, 1'b0);
        run_mask(4'b1000);
        drain();
        total = total + 1;
        if (acc_count - a0 !== 2 || rsp_count - r0 !== 2)
            $display("FAIL overlap_count: got acc=%0d rsp=%0d required 2/2", acc_count - a0, rsp_count - r0);
        else passed = passed + 1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_fairness();
        test_en_gating();
        test_reset_mid();
        test_back_to_back();
        total = total + 1;
        if (sb.size() != 0) $display("FAIL sb_empty: got %0d pending required 0", sb.size());
        else passed = passed + 1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
